dram_banked_open_row: RTL and testbench
=======================================

// Module: dram_banked_open_row
// PURPOSE
// Parametrised multi-bank DRAM timing model for the PIM datapath; it follows the single-bank burst DRAM.
// Each bank tracks its own open row, so row hits skip activation. A conflicting row costs precharge plus activate.
// Requests use a valid/ready handshake. Data moves in BURST_W-bit beats.
// Sits between the memory controller and the matrix operand buffers. Counts row hits, misses and conflicts.
// PARAMETERS
// NUM_BANKS   4    number of independent banks (>=1)
// NUM_ROWS    16   rows per bank (>=1, need not be power of 2)
// ROW_W       256  bits per row
// BURST_W     64   bits per beat; ROW_W % BURST_W == 0; BL = ROW_W/BURST_W beats per access
// T_RCD       4    ACTIVATE duration in cycles (>=1)
// T_RP        3    PRECHARGE duration in cycles (>=1)
// OPEN_PAGE   1    1: row left open after access; 0: auto-precharge after every access
// CNT_W       16   width of statistics counters
// PORTS
// clk          in   1                    clock, all logic on rising edge
// rst_n        in   1                    asynchronous active-low reset
// req_valid    in   1                    request present
// req_ready    out  1                    block can accept a request
// req_write    in   1                    1 = write burst, 0 = read burst
// req_bank     in   $clog2(NUM_BANKS)    target bank (width min 1)
// req_row      in   $clog2(NUM_ROWS)     target row (width min 1)
// wdata        in   BURST_W              write beat, sampled on each edge with w_ready=1
// w_ready      out  1                    write beat consumed this cycle
// rdata        out  BURST_W              read beat
// rvalid       out  1                    rdata valid this cycle
// rlast        out  1                    final beat of read burst
// done         out  1                    one-cycle pulse: request finished
// err          out  1                    one-cycle pulse with done: req_row >= NUM_ROWS, no access made
// hit_cnt, miss_cnt, conflict_cnt  out  CNT_W  saturating statistics
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, all bank open flags cleared, counters 0, req_ready=1, all other outputs 0.
// - Memory array is NOT reset; its contents survive reset. rdata is 0 whenever rvalid=0.
// - States: IDLE, PRECHARGE, ACTIVATE, READ_BURST, WRITE_BURST, AUTO_PRE, DONE.
// - req_ready=1 only in IDLE. A handshake latches write, bank and row. Next state is chosen at that edge:
//   - row invalid -> DONE with err
//   - bank open and same row (hit) -> READ_BURST / WRITE_BURST; hit_cnt++
//   - bank closed (miss) -> ACTIVATE; miss_cnt++
//   - bank open on a different row (conflict) -> PRECHARGE; conflict_cnt++
// - PRECHARGE holds T_RP cycles, clears the bank open flag, then goes to ACTIVATE.
// - ACTIVATE holds T_RCD cycles, sets the open flag and row for the bank, then goes to the burst state.
// - Beat counter runs 0..BL-1. Beat k maps to row bits [k*BURST_W +: BURST_W] (beat 0 = LSBs).
// - READ_BURST lasts exactly BL cycles, with no backpressure.
//   - rvalid=1, rdata=beat k (combinational from array), rlast=1 on k=BL-1.
// - WRITE_BURST lasts exactly BL cycles, with w_ready=1. wdata is written to beat k at each edge.
// - After the last beat: OPEN_PAGE=1 goes to DONE. OPEN_PAGE=0 goes to AUTO_PRE for T_RP cycles, clears the open flag, then goes to DONE.
// - DONE lasts 1 cycle (done=1), then goes to IDLE. Back-to-back requests have at least 1 idle cycle between done and the next accept.
// - Latency from accept edge to first beat:
//   - hit: 1 cycle
//   - miss: T_RCD+1 cycles
//   - conflict: T_RP+T_RCD+1 cycles
// - Open flags of banks other than the target are never changed by a request.
// - Counters saturate at all-ones and never wrap.
// - rst_n asserted mid-burst aborts immediately. Beats already written stay written. All banks are left closed.
// TESTING
// - Write bank0 row3 beats A0..A3, then read bank0 row3 -> miss (miss_cnt=1), then hit (hit_cnt=1); rdata=A0..A3, rlast on 4th beat.
// - Read bank0 row5 after row3 is open -> conflict_cnt=1; first rvalid exactly T_RP+T_RCD+1=8 cycles after accept.
// - Open row 2 in bank1 and row 7 in bank2, then read bank1 row2 -> hit; bank2 still open (next row7 access is a hit).
// - OPEN_PAGE=0: two reads of the same row -> both misses, AUTO_PRE lasting T_RP cycles before each done.
// - req_row=NUM_ROWS with NUM_ROWS=12 -> done and err asserted together 1 cycle after accept; no beats, counters unchanged.
// - Drop rst_n at beat 2 of a write -> outputs 0 immediately; beats 0-1 stored, next access to that bank counts as a miss.

Source files
------------

// File: rtl/dram_banked_open_row.sv
`default_nettype none
// ==========================================================================
// dram_banked_open_row : multi-bank DRAM timing model with per-bank open row
// Revision 1.0
// ==========================================================================
module dram_banked_open_row #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_ROWS  = 16,
  parameter int ROW_W     = 256,
  parameter int BURST_W   = 64,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 3,
  parameter int OPEN_PAGE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             req_valid,
  output logic                                             req_ready,
  input  logic                                             req_write,
  input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] req_bank,
  input  logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0]   req_row,
  input  logic [BURST_W-1:0]                               wdata,
  output logic                                             w_ready,
  output logic [BURST_W-1:0]                               rdata,
  output logic                                             rvalid,
  output logic                                             rlast,
  output logic                                             done,
  output logic                                             err,
  output logic [CNT_W-1:0]                                 hit_cnt,
  output logic [CNT_W-1:0]                                 miss_cnt,
  output logic [CNT_W-1:0]                                 conflict_cnt
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROW_IW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int BL     = ROW_W / BURST_W;
  localparam int BEAT_W = (BL > 1) ? $clog2(BL) : 1;
  localparam int DEPTH  = NUM_BANKS * NUM_ROWS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int T_MAX  = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BL - 1);
  localparam logic [TMR_W-1:0]  RP_END    = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0]  RCD_END   = TMR_W'(T_RCD - 1);
  localparam logic [ROW_IW:0]   ROW_LIM   = (ROW_IW + 1)'(NUM_ROWS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_APRE = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q;
  logic [BEAT_W-1:0] beat_q;
  logic              write_q, err_q;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_IW-1:0] row_q;
  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_IW-1:0] open_row_q [NUM_BANKS];
  logic [CNT_W-1:0]  hit_q, miss_q, conf_q;
  logic [BURST_W-1:0] mem_q [DEPTH][BL];

  logic              w_accept, w_row_ok, w_tgt_open, w_hit;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept   = req_valid && (state_q == S_IDLE);
  assign w_row_ok   = ({1'b0, req_row} < ROW_LIM);
  assign w_tgt_open = open_q[req_bank];
  assign w_hit      = w_tgt_open && (open_row_q[req_bank] == req_row);
  assign w_addr     = ADDR_W'(bank_q) * ADDR_W'(NUM_ROWS) + ADDR_W'(row_q);

  assign hit_cnt      = hit_q;
  assign miss_cnt     = miss_q;
  assign conflict_cnt = conf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_row_ok)       state_d = S_DONE;
          else if (w_hit)      state_d = req_write ? S_WR : S_RD;
          else if (w_tgt_open) state_d = S_PRE;
          else                 state_d = S_ACT;
        end
      end
      S_PRE:  if (tmr_q == RP_END)  state_d = S_ACT;
      S_ACT:  if (tmr_q == RCD_END) state_d = write_q ? S_WR : S_RD;
      S_RD, S_WR: begin
        if (beat_q == LAST_BEAT) state_d = (OPEN_PAGE != 0) ? S_DONE : S_APRE;
      end
      S_APRE: if (tmr_q == RP_END)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    w_ready   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD: begin
        rvalid = 1'b1;
        rlast  = (beat_q == LAST_BEAT);
        rdata  = mem_q[w_addr][beat_q];
      end
      S_WR:   w_ready = 1'b1;
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      beat_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      open_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      conf_q  <= '0;
      for (int i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
    end else begin
      if (w_accept) begin
        write_q <= req_write;
        bank_q  <= req_bank;
        row_q   <= req_row;
        err_q   <= !w_row_ok;
        if (w_row_ok) begin
          if (w_hit) begin
            if (hit_q != '1) hit_q <= hit_q + 1'b1;
          end else if (w_tgt_open) begin
            if (conf_q != '1) conf_q <= conf_q + 1'b1;
          end else begin
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
          end
        end
      end

      if (state_d != state_q)
        tmr_q <= '0;
      else if (state_q == S_PRE || state_q == S_ACT || state_q == S_APRE)
        tmr_q <= tmr_q + 1'b1;

      if ((state_q == S_RD || state_q == S_WR) && beat_q != LAST_BEAT)
        beat_q <= beat_q + 1'b1;
      else
        beat_q <= '0;

      // Bank state only changes when a timed phase completes.
      if ((state_q == S_PRE || state_q == S_APRE) && tmr_q == RP_END)
        open_q[bank_q] <= 1'b0;
      if (state_q == S_ACT && tmr_q == RCD_END) begin
        open_q[bank_q]     <= 1'b1;
        open_row_q[bank_q] <= row_q;
      end
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state_q == S_WR) mem_q[w_addr][beat_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_banked_open_row.sv
`default_nettype none
// Bench for dram_banked_open_row: directed plus random requests against a
// transaction-level model, on an open-page and a closed-page instance.
module tb_dram_banked_open_row;
  localparam int BL    = 4;
  localparam int T_RCD = 4;
  localparam int T_RP  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_bank = '0;
  logic [3:0]  req_row = '0;
  logic [63:0] wdata = '0;

  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_wready, a_rvalid, a_rlast, a_done, a_err;
  logic [63:0] a_rdata;
  logic [15:0] a_hit, a_miss, a_conf;
  logic        b_valid, b_ready, b_wready, b_rvalid, b_rlast, b_done, b_err;
  logic [63:0] b_rdata;
  logic [2:0]  b_hit, b_miss, b_conf;

  assign a_valid = req_valid && !sel;
  assign b_valid = req_valid && sel;

  dram_banked_open_row dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
    .wdata(wdata), .w_ready(a_wready), .rdata(a_rdata), .rvalid(a_rvalid),
    .rlast(a_rlast), .done(a_done), .err(a_err),
    .hit_cnt(a_hit), .miss_cnt(a_miss), .conflict_cnt(a_conf)
  );

  dram_banked_open_row #(.NUM_ROWS(12), .OPEN_PAGE(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
    .wdata(wdata), .w_ready(b_wready), .rdata(b_rdata), .rvalid(b_rvalid),
    .rlast(b_rlast), .done(b_done), .err(b_err),
    .hit_cnt(b_hit), .miss_cnt(b_miss), .conflict_cnt(b_conf)
  );

  logic        o_ready, o_wready, o_rvalid, o_rlast, o_done, o_err;
  logic [63:0] o_rdata;
  logic [15:0] o_hit, o_miss, o_conf;
  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_wready = sel ? b_wready : a_wready;
  assign o_rvalid = sel ? b_rvalid : a_rvalid;
  assign o_rlast  = sel ? b_rlast  : a_rlast;
  assign o_done   = sel ? b_done   : a_done;
  assign o_err    = sel ? b_err    : a_err;
  assign o_rdata  = sel ? b_rdata  : a_rdata;
  assign o_hit    = sel ? {13'd0, b_hit}  : a_hit;
  assign o_miss   = sel ? {13'd0, b_miss} : a_miss;
  assign o_conf   = sel ? {13'd0, b_conf} : a_conf;

  // Model: [dut][bank][row][beat], open state per bank, counters hit/miss/conflict.
  logic [63:0] mem_m [2][4][16][BL];
  bit          open_m [2][4];
  int          orow_m [2][4];
  int          cnt_m  [2][3];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 4; b++) open_m[d][b] = 1'b0;
      for (int c = 0; c < 3; c++) cnt_m[d][c] = 0;
    end
  endtask

  task automatic idle_checks(input int d, input string tag);
    sel = d[0];
    #1;
    chk({tag, "_ready"},  o_ready,  1);
    chk({tag, "_wready"}, o_wready, 0);
    chk({tag, "_rvalid"}, o_rvalid, 0);
    chk({tag, "_rdata"},  o_rdata,  0);
    chk({tag, "_done"},   o_done,   0);
    chk({tag, "_hit"},    o_hit,    0);
    chk({tag, "_miss"},   o_miss,   0);
    chk({tag, "_conf"},   o_conf,   0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_checks(0, "rstA");
    idle_checks(1, "rstB");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_req(input int d, input bit wr, input int bank, input int row,
                        input int abort_beat);
    int np, cls, cmax, first_exp, done_exp, first_obs, bw, br, k;
    bit op, ok, fin;
    logic [63:0] wd [BL];
    np   = (d == 0) ? 16 : 12;
    op   = (d == 0);
    cmax = (d == 0) ? 65535 : 7;
    ok   = row < np;
    if (!ok)                                                  cls = 3;
    else if (open_m[d][bank] && orow_m[d][bank] == row)       cls = 0;
    else if (open_m[d][bank])                                 cls = 2;
    else                                                      cls = 1;
    first_exp = (cls == 0) ? 1 : (cls == 1) ? T_RCD + 1 : T_RP + T_RCD + 1;
    done_exp  = ok ? first_exp + BL + (op ? 0 : T_RP) : 1;
    for (int i = 0; i < BL; i++) wd[i] = {$urandom, $urandom};
    first_obs = -1; bw = 0; br = 0; fin = 1'b0;

    sel = d[0]; req_write = wr; req_bank = bank[1:0]; req_row = row[3:0];
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_ready && k < 50);
    if (!o_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (cls == 0 && cnt_m[d][0] < cmax) cnt_m[d][0]++;
    if (cls == 1 && cnt_m[d][1] < cmax) cnt_m[d][1]++;
    if (cls == 2 && cnt_m[d][2] < cmax) cnt_m[d][2]++;

    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (abort_beat >= 0 && o_wready && bw == abort_beat) begin
        rst_n = 1'b0;
        model_reset();
        idle_checks(d, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (o_wready) begin
        if (first_obs < 0) first_obs = c;
        wdata = wd[bw];
        mem_m[d][bank][row][bw] = wd[bw];
        bw++;
      end
      if (o_rvalid) begin
        if (first_obs < 0) first_obs = c;
        chk("rdata", o_rdata, mem_m[d][bank][row][br]);
        chk("rlast", o_rlast, (br == BL - 1));
        br++;
      end else begin
        chk("rdata_idle", o_rdata, 0);
      end
      if (o_done) begin
        chk("err", o_err, !ok);
        chk("done_lat", c, done_exp);
        chk("ready_in_done", o_ready, 0);
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("beats", wr ? bw : br, ok ? BL : 0);
    chk("wrong_dir_beats", wr ? br : bw, 0);
    if (ok) begin
      chk("first_lat", first_obs, first_exp);
      open_m[d][bank] = op;
      orow_m[d][bank] = row;
    end
    chk("hit_cnt",  o_hit,  cnt_m[d][0]);
    chk("miss_cnt", o_miss, cnt_m[d][1]);
    chk("conf_cnt", o_conf, cnt_m[d][2]);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r;
    model_reset();
    repeat (2) @(negedge clk);
    idle_checks(0, "por_A");
    idle_checks(1, "por_B");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every row of both instances so later reads have known data.
    for (int dd = 0; dd < 2; dd++)
      for (int b = 0; b < 4; b++)
        for (int rr = 0; rr < ((dd == 0) ? 16 : 12); rr++)
          do_req(dd, 1'b1, b, rr, -1);
    do_req(0, 1'b1, 0, 3, -1);
    hard_reset();

    do_req(0, 1'b0, 0, 3, -1);
    do_req(0, 1'b0, 0, 3, -1);
    do_req(0, 1'b0, 0, 5, -1);
    do_req(0, 1'b0, 1, 2, -1);
    do_req(0, 1'b1, 2, 7, -1);
    do_req(0, 1'b0, 1, 2, -1);
    do_req(0, 1'b0, 2, 7, -1);

    do_req(1, 1'b0, 0, 4, -1);
    do_req(1, 1'b0, 0, 4, -1);
    do_req(1, 1'b0, 1, 12, -1);
    do_req(1, 1'b1, 2, 13, -1);

    do_req(0, 1'b0, 3, 1, -1);
    do_req(0, 1'b1, 3, 1, 2);
    do_req(0, 1'b0, 3, 1, -1);
    do_req(0, 1'b0, 3, 1, -1);

    for (int i = 0; i < 120; i++) begin
      d = $urandom_range(0, 1);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      do_req(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3), r, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
